// File: rtl/mole_sequencer.sv
// mole_sequencer: whack-a-mole round scheduler sharing the regfile write port, define MOLE_LFSR_EN for LFSR mole choice
module mole_sequencer #(
  parameter int SPAWN_CYCLES = 1000,
  parameter int UP_CYCLES = 5000,
  parameter int MOLE_BASE = 20,
  parameter int EVENT_REG = 19,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input logic clock,
  input logic ctrl_reset,
  input logic start,
  input logic [7:0] JA,
  input logic proc_we,
  input logic [4:0] proc_wreg,
  input logic [31:0] proc_wdata,
  output logic ctrl_writeEnable,
  output logic [4:0] ctrl_writeReg,
  output logic [31:0] data_writeReg,
  output logic [7:0] active_mask,
  output logic busy
);
  typedef enum logic [2:0] {IDLE, SPAWN_WAIT, SPAWN_WR, UP, CLEAR_WR, EVENT_WR} state_t;
  state_t state, state_n;
  logic [31:0] cnt;
  logic [2:0] cur, nxt;
  logic [7:0] ja_s1, ja_s2;
  logic hit, hit_flag, req, grant, cnt_zero;
  logic [4:0] req_reg;
  logic [31:0] req_data;
  assign hit = ja_s2[cur];
  assign cnt_zero = cnt == 32'd0;
  assign grant = req && !proc_we;
`ifdef MOLE_LFSR_EN
  logic [15:0] lfsr;
  always_ff @(posedge clock)
    lfsr <= ctrl_reset ? (LFSR_SEED == 16'h0 ? 16'h0001 : LFSR_SEED) : {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0);
  assign nxt = lfsr[2:0];
`else
  logic [2:0] rr;
  always_ff @(posedge clock)
    rr <= ctrl_reset ? 3'd0 : (state == SPAWN_WAIT && cnt_zero) ? rr + 3'd1 : rr;
  assign nxt = rr;
`endif
  always_ff @(posedge clock)
    state <= ctrl_reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = start ? SPAWN_WAIT : IDLE;
      SPAWN_WAIT: state_n = cnt_zero ? SPAWN_WR : SPAWN_WAIT;
      SPAWN_WR: state_n = grant ? UP : SPAWN_WR;
      UP: state_n = (hit || cnt_zero) ? CLEAR_WR : UP;
      CLEAR_WR: state_n = grant ? EVENT_WR : CLEAR_WR;
      EVENT_WR: state_n = grant ? (start ? SPAWN_WAIT : IDLE) : EVENT_WR;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      cnt <= 32'd0;
      cur <= 3'd0;
      active_mask <= 8'd0;
      hit_flag <= 1'b0;
      ja_s1 <= 8'd0;
      ja_s2 <= 8'd0;
    end else begin
      ja_s1 <= JA;
      ja_s2 <= ja_s1;
      case (state)
        IDLE: cnt <= 32'(SPAWN_CYCLES - 1);
        SPAWN_WAIT: begin
          cnt <= cnt - 32'd1;
          if (cnt_zero) cur <= nxt;
        end
        SPAWN_WR: if (grant) begin
          active_mask <= 8'd1 << cur;
          cnt <= 32'(UP_CYCLES - 1);
        end
        UP: begin
          cnt <= cnt - 32'd1;
          hit_flag <= hit;
        end
        CLEAR_WR: if (grant) active_mask <= 8'd0;
        EVENT_WR: cnt <= 32'(SPAWN_CYCLES - 1);
        default: ;
      endcase
    end
  end
  always_comb begin
    req = state == SPAWN_WR || state == CLEAR_WR || state == EVENT_WR;
    req_reg = state == EVENT_WR ? 5'(EVENT_REG) : 5'(MOLE_BASE) + 5'(cur);
    req_data = state == SPAWN_WR ? 32'd1 : state == CLEAR_WR ? 32'd0 : hit_flag ? 32'(cur) + 32'd1 : 32'hFFFF_FFFF;
    ctrl_writeEnable = proc_we || req;
    ctrl_writeReg = proc_we ? proc_wreg : req ? req_reg : 5'd0;
    data_writeReg = proc_we ? proc_wdata : req ? req_data : 32'd0;
    busy = state != IDLE;
  end
endmodule

// File: tb/tb_mole_sequencer.sv
// tb_mole_sequencer: table, directed and randomized reference-model checks for mole_sequencer
module tb_mole_sequencer;
  localparam int SC = 4;
  localparam int UC = 8;
  logic clock = 1'b0;
  logic ctrl_reset, start, proc_we;
  logic [7:0] JA;
  logic [4:0] proc_wreg;
  logic [31:0] proc_wdata;
  logic ctrl_writeEnable, busy;
  logic [4:0] ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [7:0] active_mask;
  int n_pass = 0;
  int n_total = 0;
  logic o_we, o_busy;
  logic [4:0] o_reg;
  logic [31:0] o_data;
  logic [7:0] o_mask;
  bit m_valid = 0;
  bit m_run, m_pend, m_mask_on, m_hit;
  int m_wait, m_up_left, m_kind, m_rr;
  int m_mole = 0;
  logic [4:0] m_preg;
  logic [31:0] m_pdat;
  logic [15:0] m_lfsr;
  logic [7:0] ja_hist[$];
  typedef struct {
    int reps;
    logic st;
    logic pwe;
    logic [4:0] pr;
    logic [31:0] pd;
    logic we;
    logic [4:0] rg;
    logic [31:0] dt;
    logic [7:0] mk;
    logic bz;
  } vec_t;
  vec_t tbl[$];
  always #5 clock = ~clock;
  mole_sequencer #(.SPAWN_CYCLES(SC), .UP_CYCLES(UC), .MOLE_BASE(20), .EVENT_REG(19), .LFSR_SEED(16'h0)) dut (
    .clock(clock),
    .ctrl_reset(ctrl_reset),
    .start(start),
    .JA(JA),
    .proc_we(proc_we),
    .proc_wreg(proc_wreg),
    .proc_wdata(proc_wdata),
    .ctrl_writeEnable(ctrl_writeEnable),
    .ctrl_writeReg(ctrl_writeReg),
    .data_writeReg(data_writeReg),
    .active_mask(active_mask),
    .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask
  task automatic model_check();
    if (!m_valid) return;
    check("model_we", o_we, proc_we | m_pend);
    check("model_reg", o_reg, proc_we ? proc_wreg : m_pend ? m_preg : 5'd0);
    check("model_data", o_data, proc_we ? proc_wdata : m_pend ? m_pdat : 32'd0);
    check("model_mask", o_mask, m_mask_on ? 32'd1 << m_mole : 32'd0);
    check("model_busy", o_busy, m_run);
  endtask
  task automatic model_update();
    bit hit;
    if (ctrl_reset) begin
      m_valid = 1;
      m_run = 0;
      m_pend = 0;
      m_mask_on = 0;
      m_up_left = 0;
      m_wait = 0;
      m_rr = 0;
      m_lfsr = 16'h0001;
      ja_hist = {8'h0, 8'h0};
      return;
    end
    if (!m_valid) return;
    hit = ja_hist[0][m_mole];
    void'(ja_hist.pop_front());
    ja_hist.push_back(JA);
    if (m_pend && !proc_we) begin
      if (m_kind == 0) begin
        m_pend = 0;
        m_mask_on = 1;
        m_up_left = UC;
      end else if (m_kind == 1) begin
        m_mask_on = 0;
        m_kind = 2;
        m_preg = 5'd19;
        m_pdat = m_hit ? 32'(m_mole + 1) : 32'hFFFF_FFFF;
      end else begin
        m_pend = 0;
        if (start) m_wait = SC;
        else m_run = 0;
      end
    end else if (m_up_left > 0) begin
      m_up_left--;
      if (hit || m_up_left == 0) begin
        m_up_left = 0;
        m_hit = hit;
        m_pend = 1;
        m_kind = 1;
        m_preg = 5'(20 + m_mole);
        m_pdat = 32'd0;
      end
    end else if (m_wait > 0) begin
      m_wait--;
      if (m_wait == 0) begin
`ifdef MOLE_LFSR_EN
        m_mole = int'(m_lfsr[2:0]);
`else
        m_mole = m_rr;
        m_rr = (m_rr + 1) % 8;
`endif
        m_pend = 1;
        m_kind = 0;
        m_preg = 5'(20 + m_mole);
        m_pdat = 32'd1;
      end
    end else if (!m_run && start) begin
      m_run = 1;
      m_wait = SC;
    end
    m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0);
  endtask
  task automatic cyc(input logic rst, input logic st, input logic [7:0] ja, input logic pwe, input logic [4:0] pr, input logic [31:0] pd);
    ctrl_reset = rst;
    start = st;
    JA = ja;
    proc_we = pwe;
    proc_wreg = pr;
    proc_wdata = pd;
    @(negedge clock);
    o_we = ctrl_writeEnable;
    o_reg = ctrl_writeReg;
    o_data = data_writeReg;
    o_mask = active_mask;
    o_busy = busy;
    model_check();
    @(posedge clock);
    model_update();
    #1;
  endtask
  task automatic port(input string name, input logic we, input logic [4:0] rg, input logic [31:0] dt, input logic [7:0] mk, input logic bz);
    check({name, "_we"}, o_we, we);
    check({name, "_reg"}, o_reg, rg);
    check({name, "_data"}, o_data, dt);
    check({name, "_mask"}, o_mask, mk);
    check({name, "_busy"}, o_busy, bz);
  endtask
  initial begin
    tbl.push_back('{1, 1, 0, 0, 0, 0, 0, 0, 8'h00, 0});
    tbl.push_back('{4, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 20, 1, 8'h00, 1});
    tbl.push_back('{8, 1, 0, 0, 0, 0, 0, 0, 8'h01, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 20, 0, 8'h01, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 19, 32'hFFFF_FFFF, 8'h00, 1});
    tbl.push_back('{4, 1, 0, 0, 0, 0, 0, 0, 8'h00, 1});
    tbl.push_back('{3, 1, 1, 5, 7, 1, 5, 7, 8'h00, 1});
    tbl.push_back('{1, 1, 0, 0, 0, 1, 21, 1, 8'h00, 1});
    tbl.push_back('{8, 0, 0, 0, 0, 0, 0, 0, 8'h02, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 21, 0, 8'h02, 1});
    tbl.push_back('{1, 0, 0, 0, 0, 1, 19, 32'hFFFF_FFFF, 8'h00, 1});
    tbl.push_back('{3, 0, 0, 0, 0, 0, 0, 0, 8'h00, 0});
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    port("reset", 0, 0, 0, 8'h00, 0);
`ifndef MOLE_LFSR_EN
    foreach (tbl[i])
      for (int r = 0; r < tbl[i].reps; r++) begin
        cyc(0, tbl[i].st, 8'h0, tbl[i].pwe, tbl[i].pr, tbl[i].pd);
        port($sformatf("tbl%0d_%0d", i, r), tbl[i].we, tbl[i].rg, tbl[i].dt, tbl[i].mk, tbl[i].bz);
      end
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    repeat (SC) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    port("hit_spawn", 1, 20, 1, 8'h00, 1);
    cyc(0, 1, 8'h08, 0, 0, 0);
    port("hit_up1", 0, 0, 0, 8'h01, 1);
    cyc(0, 1, 8'h01, 0, 0, 0);
    port("hit_up2", 0, 0, 0, 8'h01, 1);
    cyc(0, 1, 8'h01, 0, 0, 0);
    port("hit_up3", 0, 0, 0, 8'h01, 1);
    cyc(0, 1, 8'h01, 0, 0, 0);
    port("hit_up4", 0, 0, 0, 8'h01, 1);
    cyc(0, 1, 0, 0, 0, 0);
    port("hit_clear", 1, 20, 0, 8'h01, 1);
    cyc(0, 1, 0, 0, 0, 0);
    port("hit_event", 1, 19, 1, 8'h00, 1);
    repeat (SC) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    port("rr_spawn", 1, 21, 1, 8'h00, 1);
    cyc(0, 1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 9, 3);
    port("midrst", 1, 9, 3, 8'h00, 0);
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0);
      port("midrst_idle", 0, 0, 0, 8'h00, 0);
    end
    cyc(0, 1, 0, 0, 0, 0);
    repeat (SC) cyc(0, 1, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0, 0);
    port("restart_spawn", 1, 20, 1, 8'h00, 1);
`endif
    cyc(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4000; i++)
      cyc($urandom_range(0, 599) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 5) == 0 ? 8'($urandom) : 8'h0,
          $urandom_range(0, 3) == 0, 5'($urandom), $urandom);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
